// File: rtl/project_select_ctrl_if.sv
// Wishbone slave bundle between the bus and the project select controller.
// Latency: none (wires only).
// Backpressure: none; the slave answers each strobe with a one-cycle ack.
interface project_select_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/project_select_ctrl.sv
// Selects which user project owns the IO pads, with an all-off guard between owners.
// Latency: ack and read data one cycle after the strobe; outputs registered from next state.
// Backpressure: none; every access takes two cycles (hit, then ack) and is always accepted.
module project_select_ctrl #(
    parameter int          NUM_PROJ      = 8,
    parameter int          ID_W          = 3,
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter int          GUARD_DEFAULT = 16
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    project_select_ctrl_if.slave    wbs,
    output logic [NUM_PROJ-1:0]     active_o,
    output logic                    proj_rst_no,
    output logic                    busy_o
);

    localparam logic [1:0] S_OFF   = 2'd0;
    localparam logic [1:0] S_GUARD = 2'd1;
    localparam logic [1:0] S_ON    = 2'd2;

    localparam logic [ID_W:0]       NP_LIM = (ID_W+1)'(NUM_PROJ);
    localparam logic [NUM_PROJ-1:0] ONE    = {{(NUM_PROJ-1){1'b0}}, 1'b1};
    localparam logic [7:0]          G_RST  = 8'(GUARD_DEFAULT);

    logic [1:0]          state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          guard_q, guard_d;
    logic [ID_W-1:0]     cur_id_q, cur_id_d;
    logic [ID_W-1:0]     pend_id_q, pend_id_d;
    logic [15:0]         sw_cnt_q, sw_cnt_d;
    logic                en_q, en_d;
    logic                err_q, err_d;
    logic                ack_q;
    logic [31:0]         dat_q;
    logic [NUM_PROJ-1:0] active_q;
    logic                prst_q;
    logic                busy_q;

    logic                hit, wr;
    logic [1:0]          reg_sel;
    logic [ID_W-1:0]     req_id;
    logic                req_en;
    logic                ctrl_ok, ctrl_bad;
    logic [31:0]         rd_dat;
    logic                unused_bits;

    assign hit      = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_q &
                      (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign wr       = hit & wbs.wbs_we_i;
    assign reg_sel  = wbs.wbs_adr_i[3:2];
    assign req_id   = wbs.wbs_dat_i[ID_W-1:0];
    assign req_en   = wbs.wbs_dat_i[8];
    assign ctrl_ok  = wr & (reg_sel == 2'd0) & ({1'b0, req_id} < NP_LIM);
    assign ctrl_bad = wr & (reg_sel == 2'd0) & ({1'b0, req_id} >= NP_LIM);

    // Byte selects and low address bits carry no meaning here: all writes are full-word.
    assign unused_bits = ^{wbs.wbs_sel_i, wbs.wbs_adr_i[1:0], wbs.wbs_dat_i};

    // Next-state: register writes plus the OFF/GUARD/ON ownership sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        guard_d   = guard_q;
        cur_id_d  = cur_id_q;
        pend_id_d = pend_id_q;
        sw_cnt_d  = sw_cnt_q;
        en_d      = en_q;
        err_d     = err_q;

        if (ctrl_ok) begin
            err_d = 1'b0;
            en_d  = req_en;
        end else if (ctrl_bad) begin
            err_d = 1'b1;
        end

        // A running guard keeps its count; the new value only applies at the next reload.
        if (wr && reg_sel == 2'd2) begin
            guard_d = (wbs.wbs_dat_i[7:0] == 8'd0) ? 8'd1 : wbs.wbs_dat_i[7:0];
        end

        case (state_q)
            S_OFF: begin
                if (ctrl_ok && req_en) begin
                    pend_id_d = req_id;
                    cnt_d     = guard_q;
                    state_d   = S_GUARD;
                end
            end
            S_GUARD: begin
                if (ctrl_ok) begin
                    if (req_en) begin
                        pend_id_d = req_id;
                        cnt_d     = guard_q;
                    end else begin
                        state_d = S_OFF;
                    end
                end else if (cnt_q == 8'd1) begin
                    cur_id_d = pend_id_q;
                    sw_cnt_d = sw_cnt_q + 16'd1;
                    state_d  = S_ON;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_ON: begin
                if (ctrl_ok) begin
                    if (!req_en) begin
                        state_d = S_OFF;
                    end else if (req_id != cur_id_q) begin
                        pend_id_d = req_id;
                        cnt_d     = guard_q;
                        state_d   = S_GUARD;
                    end
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    // Read mux over the current register contents.
    always_comb begin
        rd_dat = '0;
        case (reg_sel)
            2'd0: begin
                rd_dat[ID_W-1:0] = pend_id_q;
                rd_dat[8]        = en_q;
            end
            2'd1: begin
                rd_dat[ID_W-1:0] = cur_id_q;
                rd_dat[8]        = (state_q == S_ON);
                rd_dat[9]        = (state_q == S_GUARD);
                rd_dat[10]       = err_q;
                rd_dat[31:16]    = sw_cnt_q;
            end
            2'd2:    rd_dat[7:0] = guard_q;
            default: rd_dat = '0;
        endcase
    end

    // State, bus response and outputs; outputs derive from next state so they are glitch-free flops.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= S_OFF;
            cnt_q     <= 8'd0;
            guard_q   <= G_RST;
            cur_id_q  <= '0;
            pend_id_q <= '0;
            sw_cnt_q  <= 16'd0;
            en_q      <= 1'b0;
            err_q     <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= 32'd0;
            active_q  <= '0;
            prst_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            guard_q   <= guard_d;
            cur_id_q  <= cur_id_d;
            pend_id_q <= pend_id_d;
            sw_cnt_q  <= sw_cnt_d;
            en_q      <= en_d;
            err_q     <= err_d;
            ack_q     <= hit;
            dat_q     <= (hit && !wbs.wbs_we_i) ? rd_dat : 32'd0;
            active_q  <= (state_d == S_ON) ? (ONE << cur_id_d) : '0;
            prst_q    <= (state_d == S_ON);
            busy_q    <= (state_d == S_GUARD);
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign active_o      = active_q;
    assign proj_rst_no   = prst_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_project_select_ctrl.sv
// Directed bench for project_select_ctrl with a timestamp-based ownership model.
// Latency: checks outputs every falling edge; bus accesses take hit + ack cycles.
// Backpressure: n/a.
module tb_project_select_ctrl;

    localparam int          NP   = 8;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    project_select_ctrl_if bus();
    logic [NP-1:0] active;
    logic          prst_n;
    logic          busy;

    project_select_ctrl #(
        .NUM_PROJ(8), .ID_W(4), .BASE_ADDR(BASE), .GUARD_DEFAULT(16)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs(bus),
        .active_o(active), .proj_rst_no(prst_n), .busy_o(busy)
    );

    int checks = 0;
    int passes = 0;
    int cycle  = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Model: who owns the pads, and at which cycle a pending owner takes over.
    bit          m_on, m_pending, m_err, m_en;
    int          m_cur, m_pend, m_act_cyc, m_guard;
    logic [15:0] m_sw;

    function automatic void model_reset();
        m_on = 0; m_pending = 0; m_err = 0; m_en = 0;
        m_cur = 0; m_pend = 0; m_act_cyc = 0; m_guard = 16; m_sw = 16'd0;
    endfunction

    function automatic void model_commit(int c);
        if (m_pending && c >= m_act_cyc) begin
            m_on = 1; m_cur = m_pend; m_pending = 0; m_sw = m_sw + 16'd1;
        end
    endfunction

    // CTRL write accepted on cycle n; a new owner appears guard+1 cycles later.
    function automatic void model_ctrl(int n, logic [31:0] d);
        int id;
        bit en;
        id = int'(d[3:0]);
        en = d[8];
        if (id >= NP) begin
            m_err = 1;
            return;
        end
        m_err = 0;
        m_en  = en;
        if (!en) begin
            m_on = 0; m_pending = 0;
        end else if (!(m_on && id == m_cur)) begin
            m_on = 0; m_pending = 1; m_pend = id; m_act_cyc = n + m_guard + 1;
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cycle);
    endtask

    // Per-cycle comparison against the model.
    initial begin
        logic [NP-1:0] exp_act;
        forever begin
            @(negedge clk);
            model_commit(cycle);
            exp_act = m_on ? (NP'(1) << m_cur) : '0;
            chk("active", active, exp_act);
            chk("proj_rst_n", prst_n, m_on);
            chk("busy", busy, m_pending);
            chk("onehot", ($countones(active) <= 1), 1);
            if (!bus.wbs_ack_o) chk("dat_idle", bus.wbs_dat_o, 0);
        end
    end

    task automatic wait_to(input int c);
        while (cycle < c) @(negedge clk);
    endtask

    task automatic bus_acc(input bit we, input logic [3:0] off, input logic [31:0] wdat,
                           output logic [31:0] rdat, output int n);
        @(posedge clk); #1;
        bus.wbs_stb_i = 1; bus.wbs_cyc_i = 1; bus.wbs_we_i = we;
        bus.wbs_adr_i = BASE + {28'd0, off}; bus.wbs_dat_i = wdat;
        n = cycle;
        @(negedge clk); #1;
        if (we && off[3:2] == 2'd0) model_ctrl(n, wdat);
        if (we && off[3:2] == 2'd2) m_guard = (wdat[7:0] == 8'd0) ? 1 : int'(wdat[7:0]);
        @(posedge clk); #1;
        chk("ack", bus.wbs_ack_o, 1);
        rdat = bus.wbs_dat_o;
        bus.wbs_stb_i = 0; bus.wbs_cyc_i = 0; bus.wbs_we_i = 0;
        @(posedge clk); #1;
        chk("ack_pulse", bus.wbs_ack_o, 0);
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d, output int n);
        logic [31:0] r;
        bus_acc(1'b1, off, d, r, n);
    endtask

    task automatic rd(input logic [3:0] off, input string nm, input logic [31:0] mask,
                      input logic [31:0] exp);
        logic [31:0] r;
        int n;
        bus_acc(1'b0, off, 32'd0, r, n);
        chk(nm, r & mask, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, n2, cnt_busy, cnt_zero, first_on;
        bus.wbs_stb_i = 0; bus.wbs_cyc_i = 0; bus.wbs_we_i = 0;
        bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_active", active, 0);
        chk("rst_prst", prst_n, 0);
        @(negedge clk); rst_n = 1;
        rd(4'h4, "rst_status", 32'hFFFF_FFFF, 32'h0000_0000);
        rd(4'h8, "rst_guard", 32'hFFFF_FFFF, 32'd16);

        // Select project 3 with the default 16-cycle guard
        wr(4'h0, 32'h103, n);
        cnt_busy = 0; first_on = -1;
        for (int i = 1; i <= 17; i++) begin
            wait_to(n + i);
            cnt_busy += int'(busy);
            if (active != 0 && first_on < 0) first_on = i;
        end
        chk("sel3_busy_len", cnt_busy, 16);
        chk("sel3_first_on", first_on, 17);
        chk("sel3_active", active, 8'b0000_1000);
        chk("sel3_prst", prst_n, 1);
        rd(4'h4, "sel3_status", 32'hFFFF_FFFF, 32'h0001_0103);
        rd(4'h0, "sel3_ctrl", 32'hFFFF_FFFF, 32'h0000_0103);

        // Switch 3 -> 5 with a 4-cycle guard
        wr(4'h8, 32'd4, n);
        rd(4'h8, "guard4", 32'hFFFF_FFFF, 32'd4);
        wr(4'h0, 32'h105, n);
        cnt_zero = 0;
        for (int i = 1; i <= 5; i++) begin
            wait_to(n + i);
            if (active == 0) cnt_zero++;
        end
        chk("sw5_zero_cycles", cnt_zero, 4);
        chk("sw5_active", active, 8'b0010_0000);
        rd(4'h4, "sw5_status", 32'hFFFF_FFFF, 32'h0002_0105);

        // Out-of-range ID sets err without disturbing ownership; a valid write clears it
        wr(4'h0, 32'h10A, n);
        chk("bad_id_active", active, 8'b0010_0000);
        rd(4'h4, "bad_id_status", 32'hFFFF_FFFF, 32'h0002_0505);
        wr(4'h0, 32'h000, n);
        chk("off_active", active, 0);
        rd(4'h4, "off_status", 32'hFFFF_FF00, 32'h0002_0000);

        // Mid-guard retarget restarts the count
        wr(4'h8, 32'd8, n);
        wr(4'h0, 32'h101, n);
        wr(4'h0, 32'h102, n2);
        chk("retarget_gap", n2 - n, 3);
        wait_to(n + 9);
        chk("retarget_no_p1", active, 0);
        wait_to(n2 + 8);
        chk("retarget_still_guard", busy, 1);
        wait_to(n2 + 9);
        chk("retarget_p2", active, 8'b0000_0100);
        rd(4'h4, "retarget_status", 32'hFFFF_FFFF, 32'h0003_0102);

        // Mid-guard disable: no activation ever
        wr(4'h0, 32'h101, n);
        wr(4'h0, 32'h000, n2);
        wait_to(n + 20);
        chk("disable_active", active, 0);
        chk("disable_busy", busy, 0);
        rd(4'h4, "disable_status", 32'hFFFF_FF00, 32'h0003_0000);

        // GUARD of 0 stores 1; a GUARD write mid-guard leaves the running count alone
        wr(4'h8, 32'd0, n);
        rd(4'h8, "guard0", 32'hFFFF_FFFF, 32'd1);
        wr(4'h8, 32'd6, n);
        wr(4'h0, 32'h106, n);
        wr(4'h8, 32'd2, n2);
        wait_to(n + 6);
        chk("guard_live_off", active, 0);
        wait_to(n + 7);
        chk("guard_live_on", active, 8'b0100_0000);
        wr(4'h0, 32'h106, n);
        wait_to(n + 3);
        chk("same_id_hold", active, 8'b0100_0000);

        // Register map edges
        rd(4'hC, "reg_c", 32'hFFFF_FFFF, 32'd0);
        wr(4'hC, 32'hFFFF_FFFF, n);
        wr(4'h4, 32'hFFFF_FFFF, n);
        rd(4'h4, "status_ro", 32'hFFFF_FFFF, 32'h0004_0106);

        // Outside the register block: no ack
        @(posedge clk); #1;
        bus.wbs_stb_i = 1; bus.wbs_cyc_i = 1; bus.wbs_we_i = 0;
        bus.wbs_adr_i = BASE + 32'h10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("miss_no_ack", bus.wbs_ack_o, 0);
        end
        bus.wbs_stb_i = 0; bus.wbs_cyc_i = 0;

        // Async reset while ON clears outputs before any clock edge
        @(posedge clk); #2;
        rst_n = 0;
        model_reset();
        #1;
        chk("arst_active", active, 0);
        chk("arst_prst", prst_n, 0);
        chk("arst_busy", busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1;
        rd(4'h4, "arst_status", 32'hFFFF_FFFF, 32'h0000_0000);
        rd(4'h8, "arst_guard", 32'hFFFF_FFFF, 32'd16);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
